// File: rtl/dcache_ctrl.sv
// dcache_ctrl: direct-mapped, write-back, write-allocate data cache for the memory stage.
// It has 2**IDX_W lines, and each line holds four 16-bit words.
// A miss first writes back a dirty victim line, then fills the line, then completes the request.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   Addr, DataIn        byte address and store data from the memory stage
//   Rd, Wr              load / store request (held by the pipeline while Stall=1)
//   DataOut             load data, valid with Done on a load
//   Done, Stall         access complete this cycle / hold the memory stage
//   CacheHit            Done this cycle came from an IDLE-state hit
//   err                 illegal request (odd address, or Rd and Wr together)
//   mem_addr, mem_wdata word-aligned memory address and writeback data
//   mem_rd, mem_wr      one word issued per cycle, held while mem_busy=1
//   mem_busy            memory cannot accept the issued word this cycle
//   mem_rvalid          read data return, in issue order
//   mem_rdata           returned word
//   req_count,          present only with DCACHE_STATS_EN defined:
//   hit_count           saturating counts of Done / CacheHit cycles
//
// Optional feature macro: DCACHE_STATS_EN
//
// state | meaning
// IDLE  | serve hits, flag illegal requests, detect misses
// WB    | write the dirty victim line back, words 0..3
// FILL  | issue reads for words 0..3 of the requested line
// WAIT  | all reads issued, collect the remaining returns
// CMPL  | apply the held load/store to the freshly filled line
module dcache_ctrl #(
    parameter int IDX_W = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] Addr,
    input  logic [15:0] DataIn,
    input  logic        Rd,
    input  logic        Wr,
    output logic [15:0] DataOut,
    output logic        Done,
    output logic        Stall,
    output logic        CacheHit,
    output logic        err,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    output logic        mem_rd,
    output logic        mem_wr,
    input  logic        mem_busy,
    input  logic        mem_rvalid,
    input  logic [15:0] mem_rdata
`ifdef DCACHE_STATS_EN
    ,
    output logic [31:0] req_count,
    output logic [31:0] hit_count
`endif
);
    localparam int TAG_W = 13 - IDX_W;
    localparam int LINES = 1 << IDX_W;

    typedef enum logic [2:0] {S_IDLE, S_WB, S_FILL, S_WAIT, S_CMPL} state_t;
    state_t state, state_nxt;

    logic [LINES-1:0] valid;
    logic [LINES-1:0] dirty;
    logic [TAG_W-1:0] tag_arr [LINES];
    logic [15:0]      data_arr [4*LINES];

    logic [15:1] l_addr;
    logic [15:0] l_data;
    logic        l_rd;
    logic        l_wr;
    logic [1:0]  wcnt;
    logic [1:0]  rcnt;

    logic [IDX_W-1:0] idx;
    logic [TAG_W-1:0] tag;
    logic [1:0]       word;
    logic [IDX_W-1:0] l_idx;
    logic [TAG_W-1:0] l_tag;
    logic [1:0]       l_word;
    logic             req;
    logic             bad_req;
    logic             hit;
    logic             hit_go;
    logic             miss_go;
    logic             issue_ok;
    logic             ret;
    logic             ret_last;

    assign idx    = Addr[IDX_W+2:3];
    assign tag    = Addr[15:IDX_W+3];
    assign word   = Addr[2:1];
    assign l_idx  = l_addr[IDX_W+2:3];
    assign l_tag  = l_addr[15:IDX_W+3];
    assign l_word = l_addr[2:1];

    assign req      = Rd | Wr;
    assign bad_req  = req & (Addr[0] | (Rd & Wr));
    assign hit      = valid[idx] && (tag_arr[idx] == tag);
    assign hit_go   = (state == S_IDLE) && req && !bad_req && hit;
    assign miss_go  = (state == S_IDLE) && req && !bad_req && !hit;
    // an issued word only counts once memory takes it
    assign issue_ok = ((state == S_WB) || (state == S_FILL)) && !mem_busy;
    // returns outside FILL/WAIT are leftovers of an aborted miss
    assign ret      = mem_rvalid && ((state == S_FILL) || (state == S_WAIT));
    assign ret_last = ret && (rcnt == 2'd3);

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (miss_go) state_nxt = (valid[idx] && dirty[idx]) ? S_WB : S_FILL;
            S_WB:   if (issue_ok && wcnt == 2'd3) state_nxt = S_FILL;
            // with zero memory latency the last return can coincide with the last issue
            S_FILL: if (issue_ok && wcnt == 2'd3) state_nxt = ret_last ? S_CMPL : S_WAIT;
            S_WAIT: if (ret_last) state_nxt = S_CMPL;
            S_CMPL: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        DataOut   = 16'h0;
        Done      = 1'b0;
        Stall     = 1'b0;
        CacheHit  = 1'b0;
        err       = 1'b0;
        mem_addr  = 16'h0;
        mem_wdata = 16'h0;
        mem_rd    = 1'b0;
        mem_wr    = 1'b0;
        case (state)
            S_IDLE: begin
                err = bad_req;
                if (hit_go) begin
                    Done     = 1'b1;
                    CacheHit = 1'b1;
                    if (Rd) DataOut = data_arr[{idx, word}];
                end
                if (miss_go) Stall = 1'b1;
            end
            S_WB: begin
                Stall     = 1'b1;
                mem_wr    = 1'b1;
                mem_addr  = {tag_arr[l_idx], l_idx, wcnt, 1'b0};
                mem_wdata = data_arr[{l_idx, wcnt}];
            end
            S_FILL: begin
                Stall    = 1'b1;
                mem_rd   = 1'b1;
                mem_addr = {l_addr[15:3], wcnt, 1'b0};
            end
            S_WAIT: Stall = 1'b1;
            S_CMPL: begin
                Done = 1'b1;
                if (l_rd) DataOut = data_arr[{l_idx, l_word}];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid  <= '0;
            dirty  <= '0;
            wcnt   <= 2'd0;
            rcnt   <= 2'd0;
            l_addr <= '0;
            l_data <= 16'h0;
            l_rd   <= 1'b0;
            l_wr   <= 1'b0;
        end else begin
            if (miss_go) begin
                l_addr <= Addr[15:1];
                l_data <= DataIn;
                l_rd   <= Rd;
                l_wr   <= Wr;
            end
            if (issue_ok) wcnt <= wcnt + 2'd1;
            if (ret)      rcnt <= rcnt + 2'd1;
            if (ret_last) begin
                valid[l_idx] <= 1'b1;
                dirty[l_idx] <= 1'b0;
            end
            if (hit_go && Wr) dirty[idx] <= 1'b1;
            if (state == S_CMPL && l_wr) dirty[l_idx] <= 1'b1;
        end
    end

    // Storage is not reset; valid bits alone decide whether a line means anything.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (hit_go && Wr) data_arr[{idx, word}] <= DataIn;
            if (ret) data_arr[{l_idx, rcnt}] <= mem_rdata;
            if (ret_last) tag_arr[l_idx] <= l_tag;
            if (state == S_CMPL && l_wr) data_arr[{l_idx, l_word}] <= l_data;
        end
    end

`ifdef DCACHE_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            req_count <= 32'h0;
            hit_count <= 32'h0;
        end else begin
            if (Done && req_count != 32'hFFFF_FFFF)     req_count <= req_count + 32'd1;
            if (CacheHit && hit_count != 32'hFFFF_FFFF) hit_count <= hit_count + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed bench for dcache_ctrl: memory model with fixed read latency, hand-computed expectations.
// Backing memory initial content: word at byte address a is a ^ 16'hC3C3.
module tb_dcache_ctrl;
    localparam int MEM_LAT = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [15:0] Addr;
    logic [15:0] DataIn;
    logic        Rd;
    logic        Wr;
    logic [15:0] DataOut;
    logic        Done;
    logic        Stall;
    logic        CacheHit;
    logic        err;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_rd;
    logic        mem_wr;
    logic        mem_busy;
    logic        mem_rvalid;
    logic [15:0] mem_rdata;
`ifdef DCACHE_STATS_EN
    logic [31:0] req_count;
    logic [31:0] hit_count;
`endif

    dcache_ctrl #(.IDX_W(5)) dut (
        .clk(clk), .rst(rst), .Addr(Addr), .DataIn(DataIn), .Rd(Rd), .Wr(Wr),
        .DataOut(DataOut), .Done(Done), .Stall(Stall), .CacheHit(CacheHit), .err(err),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .mem_busy(mem_busy), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
`ifdef DCACHE_STATS_EN
        , .req_count(req_count), .hit_count(hit_count)
`endif
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int start_cyc = 0;

    logic [15:0] mem_model [0:32767];
    logic [15:0] pend_addr [$];
    int          pend_due  [$];
    logic [15:0] rd_log    [$];
    int          rd_cyc    [$];
    logic [15:0] wr_log_a  [$];
    logic [15:0] wr_log_d  [$];

    logic        s_done, s_stall, s_hit, s_err, s_mrd, s_mwr;
    logic [15:0] s_dout, s_maddr;

    int          lat;
    logic [15:0] dout;
    logic        hit;
    logic        st0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Sample the current cycle at the falling edge, then advance and present any due read return.
    task automatic cycle();
        logic [15:0] a;
        @(negedge clk);
        s_done = Done; s_stall = Stall; s_hit = CacheHit; s_err = err;
        s_mrd = mem_rd; s_mwr = mem_wr; s_dout = DataOut; s_maddr = mem_addr;
        if (mem_rd && !mem_busy) begin
            pend_addr.push_back(mem_addr);
            pend_due.push_back(cyc + MEM_LAT);
            rd_log.push_back(mem_addr);
            rd_cyc.push_back(cyc);
        end
        if (mem_wr && !mem_busy) begin
            a = mem_addr;
            mem_model[a[15:1]] = mem_wdata;
            wr_log_a.push_back(mem_addr);
            wr_log_d.push_back(mem_wdata);
        end
        @(posedge clk);
        #1;
        cyc++;
        if (pend_due.size() > 0 && pend_due[0] == cyc) begin
            a = pend_addr[0];
            mem_rvalid = 1'b1;
            mem_rdata  = mem_model[a[15:1]];
            void'(pend_addr.pop_front());
            void'(pend_due.pop_front());
        end else begin
            mem_rvalid = 1'b0;
            mem_rdata  = 16'h0;
        end
    endtask

    // Hold a request until Done (at most 40 cycles); lat is the Done cycle, request cycle = 0.
    task automatic run_req(input logic rd, input logic wr, input logic [15:0] addr,
                           input logic [15:0] data, input logic [63:0] busy_mask,
                           output int l, output logic [15:0] d, output logic h, output logic s0);
        rd_log.delete(); rd_cyc.delete(); wr_log_a.delete(); wr_log_d.delete();
        Rd = rd; Wr = wr; Addr = addr; DataIn = data;
        start_cyc = cyc;
        l = -1; d = 16'hxxxx; h = 1'bx; s0 = 1'bx;
        for (int k = 0; k < 40; k++) begin
            mem_busy = busy_mask[k];
            cycle();
            if (k == 0) s0 = s_stall;
            if (s_done) begin
                l = k; d = s_dout; h = s_hit;
                break;
            end
        end
        Rd = 1'b0; Wr = 1'b0; mem_busy = 1'b0;
    endtask

    initial begin
        rst = 1'b1; Rd = 1'b0; Wr = 1'b0; Addr = 16'h0; DataIn = 16'h0;
        mem_busy = 1'b0; mem_rvalid = 1'b0; mem_rdata = 16'h0;
        for (int i = 0; i < 32768; i++) mem_model[i] = 16'(i * 2) ^ 16'hC3C3;
        @(posedge clk); #1;
        cycle(); cycle();
        rst = 1'b0;

        // no request after reset: everything quiet
        cycle();
        chk("idle_done", 32'(s_done), 32'd0);
        chk("idle_stall", 32'(s_stall), 32'd0);
        chk("idle_err", 32'(s_err), 32'd0);
        chk("idle_mem", 32'({s_mrd, s_mwr, s_hit}), 32'd0);
        chk("idle_bus", 32'({s_dout, s_maddr}), 32'd0);
`ifdef DCACHE_STATS_EN
        chk("stats_reset", {req_count | hit_count}, 32'd0);
`endif

        // 1: cold load miss
        run_req(1'b1, 1'b0, 16'h0010, 16'h0, 64'h0, lat, dout, hit, st0);
        chk("t1_lat", 32'(lat), 32'd7);
        chk("t1_stall0", 32'(st0), 32'd1);
        chk("t1_hit", 32'(hit), 32'd0);
        chk("t1_data", 32'(dout), 32'h0000C3D3);
        chk("t1_nrd", 32'(rd_log.size()), 32'd4);
        if (rd_log.size() == 4) begin
            chk("t1_rd0", 32'(rd_log[0]), 32'h0010);
            chk("t1_rd3", 32'(rd_log[3]), 32'h0016);
            chk("t1_rdc0", 32'(rd_cyc[0] - start_cyc), 32'd1);
            chk("t1_rdc3", 32'(rd_cyc[3] - start_cyc), 32'd4);
        end
        chk("t1_nwr", 32'(wr_log_a.size()), 32'd0);

        // 2: store hit, then load hit of the stored word
        run_req(1'b0, 1'b1, 16'h0012, 16'hBEEF, 64'h0, lat, dout, hit, st0);
        chk("t2w_lat", 32'(lat), 32'd0);
        chk("t2w_hit", 32'(hit), 32'd1);
        chk("t2w_stall0", 32'(st0), 32'd0);
        run_req(1'b1, 1'b0, 16'h0012, 16'h0, 64'h0, lat, dout, hit, st0);
        chk("t2r_lat", 32'(lat), 32'd0);
        chk("t2r_hit", 32'(hit), 32'd1);
        chk("t2r_data", 32'(dout), 32'h0000BEEF);

        // 3: conflicting tag on the dirty line -> writeback then fill
        run_req(1'b1, 1'b0, 16'h0110, 16'h0, 64'h0, lat, dout, hit, st0);
        chk("t3_lat", 32'(lat), 32'd11);
        chk("t3_hit", 32'(hit), 32'd0);
        chk("t3_data", 32'(dout), 32'h0000C2D3);
        chk("t3_nwr", 32'(wr_log_a.size()), 32'd4);
        if (wr_log_a.size() == 4) begin
            chk("t3_wa0", 32'(wr_log_a[0]), 32'h0010);
            chk("t3_wa3", 32'(wr_log_a[3]), 32'h0016);
            chk("t3_wd0", 32'(wr_log_d[0]), 32'hC3D3);
            chk("t3_wd1", 32'(wr_log_d[1]), 32'hBEEF);
            chk("t3_wd2", 32'(wr_log_d[2]), 32'hC3D7);
        end
        if (rd_log.size() > 0) chk("t3_rd0", 32'(rd_log[0]), 32'h0110);
        else chk("t3_nrd", 32'(rd_log.size()), 32'd4);
        // evicted line is now clean: reload sees the written-back word
        run_req(1'b1, 1'b0, 16'h0012, 16'h0, 64'h0, lat, dout, hit, st0);
        chk("t3b_lat", 32'(lat), 32'd7);
        chk("t3b_data", 32'(dout), 32'h0000BEEF);
        chk("t3b_nwr", 32'(wr_log_a.size()), 32'd0);

        // 4: illegal requests
        Rd = 1'b1; Addr = 16'h0013;
        cycle();
        chk("t4a_err", 32'(s_err), 32'd1);
        chk("t4a_done_stall", 32'({s_done, s_stall}), 32'd0);
        chk("t4a_mem", 32'({s_mrd, s_mwr}), 32'd0);
        Rd = 1'b1; Wr = 1'b1; Addr = 16'h0020; DataIn = 16'h5555;
        cycle();
        chk("t4b_err", 32'(s_err), 32'd1);
        chk("t4b_done_stall", 32'({s_done, s_stall}), 32'd0);
        Rd = 1'b0; Wr = 1'b1; Addr = 16'h0013; DataIn = 16'h1111;
        cycle();
        chk("t4c_err", 32'(s_err), 32'd1);
        Wr = 1'b0;
        cycle();
        chk("t4_quiet_mem", 32'({s_mrd, s_mwr}), 32'd0);
        run_req(1'b1, 1'b0, 16'h0012, 16'h0, 64'h0, lat, dout, hit, st0);
        chk("t4_nochg_lat", 32'(lat), 32'd0);
        chk("t4_nochg_data", 32'(dout), 32'h0000BEEF);

        // 5: memory busy for three cycles during FILL
        run_req(1'b1, 1'b0, 16'h0030, 16'h0, 64'h1C, lat, dout, hit, st0);
        chk("t5_lat", 32'(lat), 32'd10);
        chk("t5_data", 32'(dout), 32'h0000C3F3);
        chk("t5_nrd", 32'(rd_log.size()), 32'd4);
        if (rd_log.size() == 4) begin
            chk("t5_rd1", 32'(rd_log[1]), 32'h0032);
            chk("t5_rd2", 32'(rd_log[2]), 32'h0034);
            chk("t5_rd3", 32'(rd_log[3]), 32'h0036);
            chk("t5_rdc1", 32'(rd_cyc[1] - start_cyc), 32'd5);
        end

        // 6: reset in WAIT, stale return arrives in IDLE, same address misses again
        Rd = 1'b1; Addr = 16'h0040;
        for (int k = 0; k < 5; k++) cycle();
        chk("t6_wait_stall", 32'(s_stall), 32'd1);
        rst = 1'b1; Rd = 1'b0;
        cycle();
        rst = 1'b0;
        cycle();
        chk("t6_idle_after_rst", 32'({s_stall, s_done}), 32'd0);
`ifdef DCACHE_STATS_EN
        chk("t6_stats_rst", {req_count | hit_count}, 32'd0);
`endif
        run_req(1'b1, 1'b0, 16'h0040, 16'h0, 64'h0, lat, dout, hit, st0);
        chk("t6_lat", 32'(lat), 32'd7);
        chk("t6_hit", 32'(hit), 32'd0);
        chk("t6_data", 32'(dout), 32'h0000C383);
`ifdef DCACHE_STATS_EN
        chk("t6_req_count", req_count, 32'd1);
        chk("t6_hit_count", hit_count, 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
